// File: rtl/serial_nibble_feeder.sv
// Serializes a 4-bit word MSB first into a downstream shift register, one shift_en strobe per CLK_DIV clocks.
// Every output is registered; abort or reset cancels the frame without a frame_done pulse.
module serial_nibble_feeder #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] data_in,
  input  logic       load,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       sd,
  output logic       shift_en,
  output logic       frame_done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
      $error("serial_nibble_feeder: CLK_DIV must be within 1..255");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [3:0] word_q, word_d;
  logic [7:0] presc_q, presc_d;
  logic [1:0] bit_q, bit_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       sd_q, sd_d;
  logic       shift_en_q, shift_en_d;
  logic       frame_done_q, frame_done_d;

  // Next-state values are computed one cycle ahead so every output can come straight from a flop.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    presc_d      = presc_q;
    bit_d        = bit_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    sd_d         = sd_q;
    shift_en_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (load && ready_q && !abort) begin
          state_d    = SHIFT;
          word_d     = data_in;
          presc_d    = 8'd0;
          bit_d      = 2'd0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          sd_d       = data_in[3];
          shift_en_d = (DIV_LAST == 8'd0);
        end
      end
      SHIFT: begin
        if (abort || (presc_q == DIV_LAST && bit_q == 2'd3)) begin
          // A strobe already on shift_en this cycle still completes; only the
          // natural end of the fourth bit period earns frame_done.
          state_d      = IDLE;
          presc_d      = 8'd0;
          bit_d        = 2'd0;
          ready_d      = 1'b1;
          busy_d       = 1'b0;
          sd_d         = 1'b0;
          frame_done_d = !abort;
        end else begin
          if (presc_q == DIV_LAST) begin
            presc_d = 8'd0;
            bit_d   = bit_q + 2'd1;
          end else begin
            presc_d = presc_q + 8'd1;
          end
          shift_en_d = (presc_d == DIV_LAST);
          sd_d       = word_q[~bit_d];
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        sd_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      word_q       <= 4'b0000;
      presc_q      <= 8'd0;
      bit_q        <= 2'd0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      sd_q         <= 1'b0;
      shift_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      presc_q      <= presc_d;
      bit_q        <= bit_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      sd_q         <= sd_d;
      shift_en_q   <= shift_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign sd         = sd_q;
  assign shift_en   = shift_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/serial_nibble_feeder.md
SERIAL_NIBBLE_FEEDER -- requirements
Module: serial_nibble_feeder

Interface
REQ-001 SHALL provide parameter: CLK_DIV, default 4, clock cycles per serial bit period; legal range 1..255.
REQ-002 SHALL provide port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port: resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: data_in  input  4  parallel word to serialize.
REQ-005 SHALL provide port: load  input  1  request; word on data_in is captured when load and ready are both high at a rising edge.
REQ-006 SHALL provide port: abort  input  1  synchronous cancel of the frame in progress.
REQ-007 SHALL provide port: ready  output  1  high when a new word can be accepted.
REQ-008 SHALL provide port: busy  output  1  high while a frame is being shifted out.
REQ-009 SHALL provide port: sd  output  1  serial data bit for the downstream 4-bit shift-register stage.
REQ-010 SHALL provide port: shift_en  output  1  one-cycle strobe; downstream register shifts sd in when high.
REQ-011 SHALL provide port: frame_done  output  1  one-cycle pulse after the fourth bit is strobed.

Function
REQ-012 SHALL register all outputs; no combinational path from any input to any output.
REQ-013 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT on accepted load; SHIFT->IDLE after the 4th strobe or on abort.
REQ-014 SHALL in IDLE drive ready=1, busy=0, sd=0, shift_en=0.
REQ-015 SHALL on acceptance (edge E0) capture data_in, clear an 8-bit prescaler to 0 and a 2-bit bit index to 0, and drive ready=0, busy=1 from cycle 1 (the cycle after E0).
REQ-016 SHALL transmit MSB first: bit index i (0..3) drives sd=word[3-i], so the downstream register holds q=word after the fourth strobe.
REQ-017 SHALL hold sd stable for the whole bit period; sd changes only in the cycle after a strobe.
REQ-018 SHALL assert shift_en in cycles k*CLK_DIV after E0, for k=1..4, exactly one cycle each; with CLK_DIV=1 strobes occur in cycles 1,2,3,4.
REQ-019 SHALL make the prescaler count 0..CLK_DIV-1 and wrap to 0; the strobe coincides with count CLK_DIV-1.
REQ-020 SHALL in cycle 4*CLK_DIV+1 return to IDLE with ready=1, busy=0, sd=0, and frame_done=1 for that cycle only.
REQ-021 SHALL accept a load in the frame_done cycle, giving back-to-back frames with no idle gap beyond that cycle.
REQ-022 SHALL ignore load while busy; the captured word is unaffected.
REQ-023 SHALL on abort high in SHIFT go to IDLE at the next edge; no further shift_en, no frame_done.
REQ-024 SHALL, when abort and load are both high in IDLE, give abort priority and not capture the word.
REQ-025 SHALL, when abort is high in the cycle of a strobe, still emit that strobe, then go to IDLE without frame_done.

Reset
REQ-026 SHALL on resetn low immediately force ready=1, busy=0, sd=0, shift_en=0, frame_done=0, state=IDLE, prescaler=0, bit index=0, captured word=4'b0000.
REQ-027 SHALL, when reset is asserted mid-frame, discard the frame; after release no strobe occurs until a new load is accepted.
REQ-028 SHALL accept a load at the first rising edge after resetn deasserts.

Verification
REQ-029 SHALL cover: CLK_DIV=4, load data_in=4'b1011 -> sd=1,0,1,1; shift_en in cycles 4,8,12,16; frame_done in cycle 17; downstream q=4'b1011.
REQ-030 SHALL cover: CLK_DIV=1, load 4'b0110 -> shift_en in cycles 1..4 with sd=0,1,1,0; frame_done in cycle 5.
REQ-031 SHALL cover: load 4'b1111, then load 4'b0000 in the frame_done cycle -> second frame starts with no gap; q=4'b1111 then q=4'b0000.
REQ-032 SHALL cover: CLK_DIV=4, load 4'b1001, abort in cycle 6 -> exactly one shift_en (cycle 4); ready=1 in cycle 7; no frame_done.
REQ-033 SHALL cover: load 4'b1100 while busy with 4'b0011 -> only 4'b0011 is shifted; ready stays 0 until frame_done.
REQ-034 SHALL cover: resetn pulsed low in cycle 9 of a CLK_DIV=4 frame -> all outputs reset immediately; no shift_en after release until a new load.
